// File: rtl/cia_pkg.sv
// Shared CIA register types and constants used by the register-block modules.
package cia;
  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  localparam reg4_t SDR_ADDR   = 4'hC;
  localparam int    SP_IRQ_BIT = 3;

  typedef enum logic {SP_IDLE, SP_SHIFT} sp_state_t;
endpackage

// File: rtl/cia_serial_port.sv
// CIA serial data register and 8-bit shifter: MSB-first transmit on timer A underflows,
// receive on CNT rising edges. All state advances on phi2_dn strobes; irq_sp lasts one phi2 period.
module cia_serial_port
  import cia::*;
(
  input  logic  clk,
  input  logic  res,
  input  logic  phi2_dn,
  input  logic  we,
  input  reg4_t addr,
  input  reg8_t data,
  input  logic  spmode,
  input  logic  ta_underflow,
  input  logic  cnt_in,
  input  logic  sp_in,
  output reg8_t sdr,
  output logic  sp_out,
  output logic  cnt_out,
  output logic  irq_sp
);

  sp_state_t  state_q, state_d;
  reg8_t      sdr_q, sdr_d, shreg_q, shreg_d;
  logic [3:0] ctr_q, ctr_d;
  logic       sp_out_q, sp_out_d, cnt_out_q, cnt_out_d, irq_q, irq_d;
  logic       pending_q, pending_d, cnt_prev_q, cnt_prev_d, spmode_q, spmode_d;

  logic  wr, pend_eff, load;
  reg8_t next_byte, shifted;

  always_comb begin
    state_d    = state_q;
    sdr_d      = sdr_q;
    shreg_d    = shreg_q;
    ctr_d      = ctr_q;
    sp_out_d   = sp_out_q;
    cnt_out_d  = cnt_out_q;
    irq_d      = 1'b0;
    pending_d  = pending_q;
    cnt_prev_d = cnt_in;
    spmode_d   = spmode;
    load       = 1'b0;
    wr         = we && (addr == SDR_ADDR);
    pend_eff   = pending_q | wr;
    next_byte  = wr ? data : sdr_q;
    shifted    = {shreg_q[6:0], sp_in};

    if (wr) sdr_d = data;

    if (spmode != spmode_q) begin
      ctr_d     = 4'd0;
      pending_d = 1'b0;
      state_d   = SP_IDLE;
      cnt_out_d = 1'b1;
      sp_out_d  = 1'b1;
    end else if (spmode) begin
      pending_d = pend_eff;
      if (state_q == SP_IDLE) begin
        load = pend_eff;
      end else if (ta_underflow) begin
        cnt_out_d = ~cnt_out_q;
        ctr_d     = ctr_q + 4'd1;
        // Data changes on the falling CNT edge so the receiver samples on the rising one.
        if (cnt_out_q) begin
          sp_out_d = shreg_q[7];
          shreg_d  = {shreg_q[6:0], 1'b0};
        end
        if (ctr_q == 4'd15) begin
          irq_d = 1'b1;
          if (pend_eff) load = 1'b1;
          else          state_d = SP_IDLE;
        end
      end
      if (load) begin
        shreg_d   = next_byte;
        sp_out_d  = next_byte[7];
        pending_d = 1'b0;
        ctr_d     = 4'd0;
        state_d   = SP_SHIFT;
      end
    end else begin
      pending_d = 1'b0;
      state_d   = SP_IDLE;
      cnt_out_d = 1'b1;
      sp_out_d  = 1'b1;
      if (!cnt_prev_q && cnt_in) begin
        shreg_d = shifted;
        // A received byte overrides a coincident bus write.
        if (ctr_q == 4'd14) begin
          sdr_d = shifted;
          irq_d = 1'b1;
          ctr_d = 4'd0;
        end else begin
          ctr_d = ctr_q + 4'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= SP_IDLE;
      sdr_q      <= '0;
      shreg_q    <= '0;
      ctr_q      <= '0;
      sp_out_q   <= 1'b1;
      cnt_out_q  <= 1'b1;
      irq_q      <= 1'b0;
      pending_q  <= 1'b0;
      cnt_prev_q <= 1'b1;
      spmode_q   <= 1'b0;
    end else if (phi2_dn) begin
      state_q    <= state_d;
      sdr_q      <= sdr_d;
      shreg_q    <= shreg_d;
      ctr_q      <= ctr_d;
      sp_out_q   <= sp_out_d;
      cnt_out_q  <= cnt_out_d;
      irq_q      <= irq_d;
      pending_q  <= pending_d;
      cnt_prev_q <= cnt_prev_d;
      spmode_q   <= spmode_d;
    end
  end

  assign sdr     = sdr_q;
  assign sp_out  = sp_out_q;
  assign cnt_out = cnt_out_q;
  assign irq_sp  = irq_q;

endmodule

// File: tb/tb_cia_serial_port.sv
// Scoreboard bench for cia_serial_port: expected bits/interrupts are queued by the stimulus
// and consumed by a monitor that watches CNT falling edges and irq_sp pulses.
module tb_cia_serial_port;
  logic       clk, res, phi2_dn, we, spmode, ta_underflow, cnt_in, sp_in;
  logic [3:0] addr;
  logic [7:0] data, sdr;
  logic       sp_out, cnt_out, irq_sp;

  localparam logic [1:0] EV_BIT = 2'd0, EV_IRQ_IN = 2'd1, EV_IRQ_OUT = 2'd2;
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] sdr;
    logic       sp;
  } ev_t;

  ev_t sb[$];
  int  total, bad;
  logic mon_was, prev_cnt, prev_irq;
  ev_t  ev;

  cia_serial_port dut (
    .clk(clk), .res(res), .phi2_dn(phi2_dn), .we(we), .addr(addr), .data(data),
    .spmode(spmode), .ta_underflow(ta_underflow), .cnt_in(cnt_in), .sp_in(sp_in),
    .sdr(sdr), .sp_out(sp_out), .cnt_out(cnt_out), .irq_sp(irq_sp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got an event, expected none at %0t", nm, $time);
  endfunction

  // Monitor: samples 1 time unit after every clock edge that carried a phi2 strobe.
  always @(posedge clk) begin
    mon_was = phi2_dn;
    #1;
    if (res) begin
      prev_cnt = 1'b1;
      prev_irq = 1'b0;
    end else if (mon_was) begin
      if (prev_cnt && !cnt_out) begin
        if (sb.size() == 0) unexpected("cnt_fall_unexpected");
        else begin
          ev = sb.pop_front();
          check("event_kind_bit", {30'd0, ev.kind}, {30'd0, EV_BIT});
          check("sp_bit", {31'd0, sp_out}, {31'd0, ev.sp});
        end
      end
      if (irq_sp) begin
        check("irq_one_period", {31'd0, prev_irq}, 32'd0);
        if (!prev_irq) begin
          if (sb.size() == 0) unexpected("irq_unexpected");
          else begin
            ev = sb.pop_front();
            check("event_kind_irq", {31'd0, ev.kind != EV_BIT}, 32'd1);
            check("irq_sdr", {24'd0, sdr}, {24'd0, ev.sdr});
            if (ev.kind == EV_IRQ_OUT) begin
              check("irq_sp_out", {31'd0, sp_out}, {31'd0, ev.sp});
              check("irq_cnt_out", {31'd0, cnt_out}, 32'd1);
            end
          end
        end
      end
      prev_cnt = cnt_out;
      prev_irq = irq_sp;
    end
  end

  task automatic tick(input logic uf, input logic w, input logic [7:0] d);
    @(negedge clk);
    ta_underflow = uf;
    we           = w;
    addr         = 4'hC;
    data         = d;
    phi2_dn      = 1'b1;
    @(negedge clk);
    phi2_dn      = 1'b0;
    ta_underflow = 1'b0;
    we           = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sb.push_back('{EV_BIT, 8'h00, b[i]});
  endtask

  task automatic edge_in(input logic b, input logic w, input logic [7:0] d);
    cnt_in = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    cnt_in = 1'b1;
    sp_in  = b;
    tick(1'b0, w, d);
  endtask

  logic [7:0] rx_a, rx_b;

  initial begin
    total = 0; bad = 0;
    prev_cnt = 1'b1; prev_irq = 1'b0;
    res = 1'b1; phi2_dn = 1'b0; we = 1'b0; addr = 4'h0; data = 8'h00;
    spmode = 1'b1; ta_underflow = 1'b0; cnt_in = 1'b0; sp_in = 1'b0;
    rx_a = 8'b0110_1101;
    rx_b = 8'b1001_0110;

    #22;
    check("rst_sdr", {24'd0, sdr}, 32'h00);
    check("rst_sp_out", {31'd0, sp_out}, 32'd1);
    check("rst_cnt_out", {31'd0, cnt_out}, 32'd1);
    check("rst_irq", {31'd0, irq_sp}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    idle(2);

    // Single byte $A5 out, underflows 4 phi2 periods apart.
    push_byte(8'hA5);
    sb.push_back('{EV_IRQ_OUT, 8'hA5, 1'b1});
    tick(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      idle(3);
    end
    check("a5_cnt_out_end", {31'd0, cnt_out}, 32'd1);
    check("a5_drained", sb.size(), 0);

    // Back-to-back: $3C, then $C3 written mid-byte reloads on the completion strobe.
    push_byte(8'h3C);
    sb.push_back('{EV_IRQ_OUT, 8'hC3, 1'b1});
    push_byte(8'hC3);
    sb.push_back('{EV_IRQ_OUT, 8'hC3, 1'b1});
    tick(1'b0, 1'b1, 8'h3C);
    for (int i = 1; i <= 32; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      if (i == 8) tick(1'b0, 1'b1, 8'hC3);
      else idle(1);
      idle(2);
    end
    check("b2b_drained", sb.size(), 0);
    check("b2b_cnt_out_end", {31'd0, cnt_out}, 32'd1);

    // No write: underflows in IDLE do nothing.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      check("idle_cnt_out", {31'd0, cnt_out}, 32'd1);
      idle(1);
    end

    // Async reset mid-transfer after 5 underflows.
    push_byte(8'hA5);
    void'(sb.pop_back()); void'(sb.pop_back()); void'(sb.pop_back());
    void'(sb.pop_back()); void'(sb.pop_back());
    tick(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 8'h00);
      idle(1);
    end
    check("pre_rst_cnt_out", {31'd0, cnt_out}, 32'd0);
    #3 res = 1'b1;
    #1;
    check("midrst_sdr", {24'd0, sdr}, 32'h00);
    check("midrst_sp_out", {31'd0, sp_out}, 32'd1);
    check("midrst_cnt_out", {31'd0, cnt_out}, 32'd1);
    check("midrst_irq", {31'd0, irq_sp}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    idle(2);
    tick(1'b1, 1'b0, 8'h00);
    idle(1);
    tick(1'b1, 1'b0, 8'h00);
    check("postrst_cnt_out", {31'd0, cnt_out}, 32'd1);
    check("postrst_sdr", {24'd0, sdr}, 32'h00);
    check("postrst_drained", sb.size(), 0);

    // Receive $6D; a write of $FF on the completion strobe loses.
    spmode = 1'b0;
    cnt_in = 1'b0;
    idle(2);
    sb.push_back('{EV_IRQ_IN, 8'h6D, 1'b0});
    for (int i = 7; i >= 0; i--) edge_in(rx_a[i], i == 0, 8'hFF);
    idle(2);
    check("rx_sdr", {24'd0, sdr}, 32'h6D);
    check("rx_sp_out_held", {31'd0, sp_out}, 32'd1);

    // Partial byte aborted by a mode toggle, then a full byte $96.
    for (int i = 0; i < 4; i++) edge_in(1'b1, 1'b0, 8'h00);
    spmode = 1'b1;
    idle(1);
    spmode = 1'b0;
    idle(1);
    check("abort_sdr_kept", {24'd0, sdr}, 32'h6D);
    sb.push_back('{EV_IRQ_IN, 8'h96, 1'b0});
    for (int i = 7; i >= 0; i--) edge_in(rx_b[i], 1'b0, 8'h00);
    idle(3);
    check("rx2_sdr", {24'd0, sdr}, 32'h96);
    check("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/cia_serial_port.md
Name: cia_serial_port

Overview:
Serial data register (SDR, register $C) and 8-bit shift engine for the CIA. It transmits bytes MSB-first on SP/CNT in output mode, clocked by timer A underflows, and receives bytes on external CNT rising edges in input mode. It produces the SP interrupt source pulse that feeds the interrupt controller's sources[3].

Parameters:
none

Ports:
clk  input  1  system clock
res  input  1  reset, asynchronous, active-high
phi2_dn  input  1  single-clk strobe marking end of phi2; all state advances only when high
we  input  1  bus write qualifier
addr  input  4  register address (cia::reg4_t)
data  input  8  write data (cia::reg8_t)
spmode  input  1  CRA bit 6 from timer A block; 1 = output, 0 = input
ta_underflow  input  1  timer A underflow, valid for the phi2_dn cycle
cnt_in  input  1  synchronized CNT pin level
sp_in  input  1  synchronized SP pin level
sdr  output  8  SDR read value (cia::reg8_t)
sp_out  output  1  SP pin drive value, output mode only
cnt_out  output  1  CNT pin drive value, output mode only
irq_sp  output  1  SP interrupt source; high for exactly one phi2 period

Behaviour:
- Reset (async, res=1): sdr=0, shreg=0, sp_out=1, cnt_out=1, irq_sp=0, half-step counter=0, pending=0, state=IDLE, cnt_prev=1.
- All registers update only on clk edges where phi2_dn=1. The only exception is async reset.
- irq_sp is registered on phi2_dn and cleared on the next phi2_dn. It is therefore stable across the following clk cycles where the interrupt block samples its sources.
- SDR write: we && addr==$C && phi2_dn. Sets sdr<=data in either mode. In output mode it also sets pending=1.
- Output mode, states IDLE / SHIFT:
  - IDLE && pending: on the same phi2_dn, shreg<=sdr, pending<=0, counter<=0, sp_out<=sdr[7], state<=SHIFT.
  - A write with the same phi2_dn sees the new data: the write is applied first, then the load.
  - SHIFT && ta_underflow: cnt_out toggles and counter increments (4 bits, 0..15).
    - cnt_out 1->0: sp_out<=shreg[7], shreg<=shreg<<1.
    - cnt_out 0->1: receiver sampling edge; no data change.
  - Completion: on the 16th underflow (counter==15, cnt_out returns to 1), irq_sp<=1.
    - If pending (including a write on the same phi2_dn): reload as above with no gap cycle.
    - Else state<=IDLE, sp_out holds the last bit, cnt_out=1.
  - ta_underflow in IDLE is ignored; cnt_out stays 1.
- Input mode:
  - Rising edge of cnt_in (cnt_prev==0 && cnt_in==1, sampled on phi2_dn): shreg<={shreg[6:0],sp_in}, counter<=counter+2.
  - On the 8th edge: sdr<=shifted value, irq_sp<=1, counter<=0.
  - If an SDR write coincides with completion, the received byte wins.
  - cnt_out=1 and sp_out=1 are held; the pin block tristates them.
  - pending is ignored and cleared.
- Mode change (spmode differs from its registered copy): abort any transfer. counter<=0, pending<=0, state<=IDLE, cnt_out<=1, sp_out<=1. shreg and sdr are kept, and no irq_sp is generated.
- Reset asserted mid-transfer returns everything to reset values immediately, with no irq_sp.
- Counter wraps only via completion; no partial byte is ever reported.

Decomposition:
- Package cia gains:
  - SDR_ADDR = 4'hC
  - enum sp_state_t {SP_IDLE, SP_SHIFT}
  - SP_IRQ_BIT = 3 (index into interrupt sources)
- Existing cia::reg4_t and cia::reg8_t are reused.
- No sub-module: the edge detector and shifter are small enough to stay inline.

Test Plan:
- Reset mid-SHIFT (after 5 underflows) -> sdr=0, sp_out=1, cnt_out=1, irq_sp=0 immediately; the next underflow causes no activity.
- spmode=1, write $A5, then 16 ta_underflow pulses spaced 4 phi2 cycles apart -> sp_out sequence on cnt_out falls is 1,0,1,0,0,1,0,1; irq_sp is high for exactly one phi2 period after the 16th underflow; cnt_out ends at 1.
- Output mode: write $3C, then write $C3 during bit 4 -> after the first byte, the second byte starts on the same phi2_dn as irq_sp with no idle gap; a second irq_sp follows 16 underflows later.
- spmode=0, drive 8 CNT rising edges with sp_in = 0,1,1,0,1,1,0,1 -> sdr=$6D and one irq_sp pulse. An SDR write of $FF on the completion cycle still reads back $6D.
- Input mode with 4 edges, then spmode toggled to 1 and back to 0 -> counter cleared and no irq_sp. 8 further edges yield a full byte.
- Output mode with no write and 10 ta_underflow pulses -> cnt_out stays 1, no irq_sp.
